queue_ip_fetcher: RTL

Front end of the QoS queue path: pops packet words from the ingress FIFO, extracts each packet's source IP, and presents it to the queue matcher with a one-cycle `fifo_out` strobe. It samples the matcher's `match` result and reports a per-packet priority class downstream through a valid/ready handshake. It also keeps saturating counts of high- and low-priority packets. It is the requesting side of the matcher's `fifo_out` / `fifo_temp_source_ip` / `match` interface.

---
 rtl/queue_ip_fetcher.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/queue_ip_fetcher.sv
// queue_ip_fetcher: pops packets from the ingress FIFO, captures each packet's
// source IP, issues a one-cycle lookup strobe to the queue matcher and reports
// the resulting priority class downstream over a valid/ready handshake.
module queue_ip_fetcher #(
    parameter int unsigned SRC_IP_WORD = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_empty,
    input  logic [31:0]      in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             in_rd_en,
    output logic             fifo_out,
    output logic [31:0]      fifo_temp_source_ip,
    input  logic             match,
    output logic             class_valid,
    output logic             class_hi,
    input  logic             class_ready,
    output logic [CNT_W-1:0] hi_count,
    output logic [CNT_W-1:0] lo_count,
    output logic             err_pkt
);

    localparam int unsigned    IDX_W     = $clog2(SRC_IP_WORD + 2);
    localparam logic [IDX_W-1:0] IP_IDX  = IDX_W'(SRC_IP_WORD);
    localparam logic [IDX_W-1:0] IDX_SAT = IDX_W'(SRC_IP_WORD + 1);
    localparam bit             IP_AT_SOP = (SRC_IP_WORD == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DRAIN,
        S_LOOKUP,
        S_WAIT,
        S_REPORT
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_ip;
    logic             r_fifo_out;
    logic             r_class_valid;
    logic             r_class_hi;
    logic [CNT_W-1:0] r_hi_count;
    logic [CNT_W-1:0] r_lo_count;
    logic             r_err_pkt;

    logic             w_fetch_state;
    logic [IDX_W-1:0] w_idx_inc;

    // Word index advance, saturating one past the IP word so long packets never wrap
    assign w_idx_inc = (r_idx == IDX_SAT) ? r_idx : r_idx + IDX_W'(1);

    // Pop only while collecting packet words; lookup/report phases backpressure the FIFO
    assign w_fetch_state = (r_state == S_IDLE) || (r_state == S_HDR) || (r_state == S_DRAIN);
    assign in_rd_en      = rst && w_fetch_state && !in_empty;

    // Packet parsing, lookup sequencing, class handshake and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_ip          <= '0;
            r_fifo_out    <= 1'b0;
            r_class_valid <= 1'b0;
            r_class_hi    <= 1'b0;
            r_hi_count    <= '0;
            r_lo_count    <= '0;
            r_err_pkt     <= 1'b0;
        end else begin
            r_fifo_out <= 1'b0;
            r_err_pkt  <= 1'b0;
            case (r_state)
                S_IDLE, S_HDR, S_DRAIN: begin
                    if (in_rd_en) begin
                        if (in_sop) begin
                            // A new SOP mid-packet abandons the current packet
                            if (r_state != S_IDLE) begin
                                r_err_pkt <= 1'b1;
                            end
                            r_idx <= '0;
                            if (IP_AT_SOP) begin
                                r_ip <= in_data;
                            end
                            if (in_eop) begin
                                if (IP_AT_SOP) begin
                                    r_state    <= S_LOOKUP;
                                    r_fifo_out <= 1'b1;
                                end else begin
                                    // Single-word packet ended before its IP word
                                    r_state   <= S_IDLE;
                                    r_err_pkt <= 1'b1;
                                end
                            end else begin
                                r_state <= IP_AT_SOP ? S_DRAIN : S_HDR;
                            end
                        end else if (r_state == S_HDR) begin
                            r_idx <= w_idx_inc;
                            if (w_idx_inc == IP_IDX) begin
                                r_ip <= in_data;
                                if (in_eop) begin
                                    r_state    <= S_LOOKUP;
                                    r_fifo_out <= 1'b1;
                                end else begin
                                    r_state <= S_DRAIN;
                                end
                            end else if (in_eop) begin
                                // Packet ended before the IP word: drop it
                                r_state   <= S_IDLE;
                                r_err_pkt <= 1'b1;
                            end
                        end else if (r_state == S_DRAIN) begin
                            r_idx <= w_idx_inc;
                            if (in_eop) begin
                                r_state    <= S_LOOKUP;
                                r_fifo_out <= 1'b1;
                            end
                        end
                        // Non-SOP words popped in IDLE are discarded
                    end
                end
                S_LOOKUP: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_class_hi    <= match;
                    r_class_valid <= 1'b1;
                    r_state       <= S_REPORT;
                end
                S_REPORT: begin
                    if (class_ready) begin
                        r_class_valid <= 1'b0;
                        r_state       <= S_IDLE;
                        if (r_class_hi) begin
                            if (r_hi_count != {CNT_W{1'b1}}) begin
                                r_hi_count <= r_hi_count + CNT_W'(1);
                            end
                        end else begin
                            if (r_lo_count != {CNT_W{1'b1}}) begin
                                r_lo_count <= r_lo_count + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_out            = r_fifo_out;
    assign fifo_temp_source_ip = r_ip;
    assign class_valid         = r_class_valid;
    assign class_hi            = r_class_hi;
    assign hi_count            = r_hi_count;
    assign lo_count            = r_lo_count;
    assign err_pkt             = r_err_pkt;

endmodule
